// File: rtl/coin_feeder.sv
// coin_feeder: turns a requested amount into 1/2/3-unit coin codes for the coin accumulator without ever overfilling a vend
//
// Ports:
//   Clk       in   1    clock, rising edge
//   Reset_n   in   1    synchronous active-low reset
//   Start     in   1    request pulse, accepted only in IDLE
//   Amount    in   AW   units to pay, captured with an accepted Start
//   Vend_In   in   1    accumulator vend flag, honoured only in WAITV
//   Coin_Out  out  2    coin code to the accumulator: 0 none, 1..3 units
//   Busy      out  1    high whenever the FSM is not IDLE
//   Done      out  1    one-cycle pulse when a request completes
//   Err       out  1    sticky vend-timeout flag, cleared by the next accepted Start
//   Vend_Cnt  out  CW   vends observed since reset, wrapping
module coin_feeder #(
  parameter int AW      = 4,
  parameter int CW      = 8,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [AW-1:0] Amount,
  input  logic          Vend_In,
  output logic [1:0]    Coin_Out,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic [CW-1:0] Vend_Cnt
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FEED  = 3'd1;
  localparam logic [2:0] GAPW  = 3'd2;
  localparam logic [2:0] WAITV = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam int TW = $clog2(TIMEOUT);
  logic [2:0]    state;
  logic [AW-1:0] rem;
  logic [2:0]    credit;
  logic [3:0]    gap_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    room;
  logic [1:0]    cap;
  logic [1:0]    c;
  logic          full;
  // c = min(rem, room left before a vend, 3): the coin never pushes credit past 4
  always_comb begin
    room     = 3'd4 - credit;
    cap      = room < 3'd3 ? room[1:0] : 2'd3;
    c        = rem < AW'(cap) ? rem[1:0] : cap;
    full     = (credit + {1'b0, c}) == 3'd4;
    Coin_Out = state == FEED ? c : 2'b00;
    Busy     = state != IDLE;
    Done     = state == DONE;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      rem      <= '0;
      credit   <= '0;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      Err      <= 1'b0;
      Vend_Cnt <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          rem   <= Amount;
          Err   <= 1'b0;
          state <= Amount == '0 ? DONE : FEED;
        end
        FEED: begin
          rem     <= rem - AW'(c);
          credit  <= credit + {1'b0, c};
          gap_cnt <= '0;
          to_cnt  <= '0;
          // a completed vend takes priority: wait for it before finishing or pausing
          state   <= full ? WAITV : rem == AW'(c) ? DONE : GAP > 0 ? GAPW : FEED;
        end
        GAPW: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == 4'(GAP - 1)) state <= FEED;
        end
        WAITV: if (Vend_In) begin
          credit   <= '0;
          Vend_Cnt <= Vend_Cnt + 1'b1;
          state    <= rem == '0 ? DONE : FEED;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          // the accumulator never vended; assume it dropped its credit and abandon the request
          Err    <= 1'b1;
          credit <= '0;
          state  <= IDLE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
